// File: rtl/if_id_fetch_queue_if.sv
// if_id_fetch_queue_if: fetch-side push, decode-side head, stage control and status of the IF/ID queue.
interface if_id_fetch_queue_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
);
  logic                     in_valid;
  logic [PC_WIDTH-1:0]      in_pc;
  logic [INSTR_WIDTH-1:0]   in_instruction;
  logic                     in_ready;
  logic                     hold_IF_ID;
  logic                     IF_Flush;
  logic                     out_valid;
  logic [PC_WIDTH-1:0]      out_pc;
  logic [INSTR_WIDTH-1:0]   out_instruction;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     overflow;
  modport master (
    output in_valid, in_pc, in_instruction, hold_IF_ID, IF_Flush,
    input  in_ready, out_valid, out_pc, out_instruction, count, full, empty, overflow
  );
  modport slave (
    input  in_valid, in_pc, in_instruction, hold_IF_ID, IF_Flush,
    output in_ready, out_valid, out_pc, out_instruction, count, full, empty, overflow
  );
endinterface

// File: rtl/if_id_fetch_queue.sv
// if_id_fetch_queue: DEPTH-entry FIFO of (PC, instruction) pairs between fetch and decode.
module if_id_fetch_queue #(
  parameter int                     PC_WIDTH    = 8,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     DEPTH       = 4,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 'h5400_0000
) (
  input logic clk,
  input logic rst,
  if_id_fetch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [AW:0]            cnt;
  logic                   ovf, full, empty, push, pop;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign push  = q.in_valid && !full;
  assign pop   = !empty && !q.hold_IF_ID;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (q.in_valid && full && !q.IF_Flush) ovf <= 1'b1;
      if (q.IF_Flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  end
  // Storage is deliberately left unreset; empty gating hides stale entries.
  always_ff @(posedge clk) begin
    if (push && !q.IF_Flush) begin
      pc_mem[wr_ptr]    <= q.in_pc;
      instr_mem[wr_ptr] <= q.in_instruction;
    end
  end
  assign q.in_ready        = !full;
  assign q.out_valid       = !empty;
  assign q.out_pc          = empty ? '0 : pc_mem[rd_ptr];
  assign q.out_instruction = empty ? NOP_INSTR : instr_mem[rd_ptr];
  assign q.count           = cnt;
  assign q.full            = full;
  assign q.empty           = empty;
  assign q.overflow        = ovf;
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// tb_if_id_fetch_queue: directed plus randomized stimulus checked against a queue-based reference model.
module tb_if_id_fetch_queue;
  localparam int PW = 8, IW = 32, D = 4;
  localparam logic [IW-1:0] NOP = 32'h5400_0000;
  typedef struct packed { logic [PW-1:0] pc; logic [IW-1:0] instr; } entry_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0, n_err = 0;
  entry_t model[$];
  logic m_ovf = 1'b0;
  if_id_fetch_queue_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(D)) q ();
  if_id_fetch_queue #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(D), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .q(q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    bit e;
    e = model.size() == 0;
    chk({tag, ".out_valid"}, 64'(q.out_valid), 64'(!e));
    chk({tag, ".out_pc"}, 64'(q.out_pc), e ? 64'd0 : 64'(model[0].pc));
    chk({tag, ".out_instr"}, 64'(q.out_instruction), e ? 64'(NOP) : 64'(model[0].instr));
    chk({tag, ".count"}, 64'(q.count), 64'(model.size()));
    chk({tag, ".full"}, 64'(q.full), 64'(model.size() == D));
    chk({tag, ".empty"}, 64'(q.empty), 64'(e));
    chk({tag, ".in_ready"}, 64'(q.in_ready), 64'(model.size() != D));
    chk({tag, ".overflow"}, 64'(q.overflow), 64'(m_ovf));
  endtask
  // Drive one cycle of inputs, advance the model by the queue rules, then check after the edge.
  task automatic cyc(input string tag, input bit v, input logic [PW-1:0] pc, input logic [IW-1:0] ins,
                     input bit hold, input bit flush);
    entry_t ent;
    bit was_full;
    q.in_valid = v; q.in_pc = pc; q.in_instruction = ins; q.hold_IF_ID = hold; q.IF_Flush = flush;
    @(posedge clk);
    ent.pc = pc; ent.instr = ins;
    was_full = model.size() == D;
    if (flush) model.delete();
    else begin
      if (v && was_full) m_ovf = 1'b1;
      if (model.size() > 0 && !hold) void'(model.pop_front());
      if (v && !was_full) model.push_back(ent);
    end
    #1 check_all(tag);
  endtask
  initial begin
    q.in_valid = 0; q.in_pc = '0; q.in_instruction = '0; q.hold_IF_ID = 0; q.IF_Flush = 0;
    #2 check_all("reset");
    #1 rst = 1'b1;
    cyc("idle", 0, 0, 0, 0, 0);
    chk("idle_nop", 64'(q.out_instruction), 64'h5400_0000);
    cyc("push_a1", 1, 8'h04, 32'hA1, 1, 0);
    chk("push_a1_pc", 64'(q.out_pc), 64'h04);
    cyc("pop_a1", 0, 0, 0, 0, 0);
    chk("pop_a1_empty", 64'(q.empty), 64'd1);
    for (int i = 1; i <= 5; i++) cyc("fill", 1, PW'(i), IW'(32'h100 + i), 1, 0);
    chk("fill_ovf", 64'(q.overflow), 64'd1);
    chk("fill_count", 64'(q.count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(q.out_pc), 64'(i + 1));
      cyc("drain", 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 10; i++) cyc("stream", 1, PW'(i), IW'(32'h200 + i), 0, 0);
    chk("stream_count", 64'(q.count), 64'd1);
    cyc("stream_end", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("pre_flush", 1, PW'(8'h10 + i), IW'(32'h300 + i), 1, 0);
    cyc("flush", 1, 8'h20, 32'h320, 0, 1);
    chk("flush_nop", 64'(q.out_instruction), 64'(NOP));
    cyc("post_flush", 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) cyc("pre_rst", 1, PW'(8'h30 + i), IW'(32'h400 + i), 1, 0);
    rst = 1'b0;
    model.delete(); m_ovf = 1'b0;
    #1 check_all("async_rst");
    chk("async_rst_ovf", 64'(q.overflow), 64'd0);
    #1 rst = 1'b1;
    q.in_valid = 0;
    for (int i = 0; i < 600; i++)
      cyc("rand", $urandom_range(0, 99) < 60, PW'($urandom), $urandom, $urandom_range(0, 99) < 45,
          $urandom_range(0, 99) < 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
Parametrised successor to the single-entry IF/ID pipeline register. It is a DEPTH-entry FIFO of (PC, instruction) pairs between instruction fetch and decode, which decouples fetch from decode stalls. It keeps the existing stage-control semantics: hold_IF_ID stalls the decode side, and IF_Flush squashes in-flight instructions. When empty it presents the architectural NOP to decode. It adds valid/ready handshaking, occupancy reporting and overflow detection, none of which the single register has.

Parameters:
PC_WIDTH, 8, width of stored PC.
INSTR_WIDTH, 32, width of stored instruction.
DEPTH, 4, number of entries; power of two, minimum 2.
NOP_INSTR, 32'h5400_0000, instruction presented when the queue is empty or after reset/flush; width INSTR_WIDTH.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  fetch presents a valid entry.
in_pc  input  PC_WIDTH  incremented PC from fetch.
in_instruction  input  INSTR_WIDTH  fetched instruction.
in_ready  output  1  queue can accept; equals !full.
hold_IF_ID  input  1  decode stall; no pop while 1.
IF_Flush  input  1  discard all entries.
out_valid  output  1  head entry valid; equals !empty.
out_pc  output  PC_WIDTH  head PC; 0 when empty.
out_instruction  output  INSTR_WIDTH  head instruction; NOP_INSTR when empty.
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
overflow  output  1  sticky flag: in_valid asserted while full.

Behaviour:
- Reset (rst=0, asynchronous): read pointer, write pointer and count go to 0; overflow goes to 0. Outputs immediately become out_valid=0, empty=1, full=0, in_ready=1, out_pc=0, out_instruction=NOP_INSTR. Storage array is not reset. Deassertion is taken synchronously at the next clk edge.
- Push: occurs when in_valid && in_ready. The entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && !hold_IF_ID. rd_ptr increments modulo DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are distinguished by count, not by pointer compare.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Push when full: not possible, because in_ready=0. If in_valid=1 while full, the entry is dropped and overflow is set to 1. overflow stays set until reset; flush does not clear it.
- Pop when empty: not possible, because out_valid=0. A push into an empty queue becomes visible on outputs the next cycle, so latency is 1 cycle and there is no fall-through bypass.
- Head outputs are combinational from storage[rd_ptr], gated by empty. When empty=1, out_pc=0 and out_instruction=NOP_INSTR.
- IF_Flush=1 at a clk edge: count=0 and rd_ptr=wr_ptr=0. Flush overrides any push or pop in the same cycle, so an in_valid entry in that cycle is discarded and does not set overflow. Outputs show NOP_INSTR from the following cycle.
- hold_IF_ID=1 with no flush: the head is frozen and pushes continue until full.
- Reset asserted mid-operation: all entries are discarded immediately, without waiting for clk.
- count changes by at most ±1 per cycle except on flush or reset.

Test Plan:
- Reset, then idle -> out_valid=0, out_instruction=32'h5400_0000, out_pc=0, count=0, in_ready=1.
- Push (pc=8'h04, instr=32'hA1) with hold_IF_ID=1 -> next cycle out_valid=1, out_pc=8'h04, out_instruction=32'hA1, count=1. Release hold -> pops; following cycle empty=1 and NOP is shown.
- Hold=1, push 5 entries (pc 1..5) with DEPTH=4 -> count=4, full=1, in_ready=0 after the 4th; the 5th is dropped and overflow=1. Release hold -> pcs 1,2,3,4 appear in order.
- Continuous push+pop for 10 cycles with pc 0..9 -> count stays 1 and output order matches input across pointer wrap.
- Queue holding 3 entries; assert IF_Flush together with in_valid (pc=8'h20) -> next cycle count=0, out_instruction=NOP_INSTR, 8'h20 never appears, overflow unchanged.
- Queue holding 2 entries; pulse rst low mid-cycle -> outputs reset immediately, before the next clk edge; overflow=0.
